mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_D_BURST, default 4: max consecutive data grants while an instruction request waits.
REQ-002 SHALL have parameter TIMEOUT, default 15: max memory-wait cycles before abort (4-bit counter).
REQ-003 SHALL have port i_clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port i_reset_n  in  1  synchronous active-low reset.
REQ-005 SHALL have ports i_d_req / i_d_wr  in  1 each  data request / write qualifier.
REQ-006 SHALL have ports i_d_addr in 32, i_d_ben in 4, i_d_wdata in 32: data address, byte enables, write data.
REQ-007 SHALL have ports o_d_ack out 1, o_d_abort out 1, o_d_rdata out 32: data completion pulse, abort flag, read data.
REQ-008 SHALL have ports i_i_req in 1, i_i_addr in 32: instruction fetch request, address.
REQ-009 SHALL have ports o_i_ack out 1, o_i_abort out 1, o_i_rdata out 32: instruction completion, abort, data.
REQ-010 SHALL have ports o_m_req, o_m_wr out 1; o_m_addr out 32; o_m_ben out 4; o_m_wdata out 32: shared memory command.
REQ-011 SHALL have ports i_m_ack in 1, i_m_rdata in 32: memory completion, read data valid with ack.
REQ-012 SHALL have port o_busy  out  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, D_XFER, I_XFER, ACK; all outputs registered.
REQ-014 In IDLE, only one request pending SHALL grant it at next edge (D_XFER or I_XFER).
REQ-015 In IDLE, both pending SHALL grant data, unless data-burst counter equals MAX_D_BURST, then grant instruction.
REQ-016 Data-burst counter SHALL increment on each data grant made while i_i_req high, saturate at MAX_D_BURST, clear on any instruction grant or when i_i_req low in IDLE.
REQ-017 On grant, o_m_req SHALL rise the cycle after the IDLE sampling edge; o_m_addr/ben/wdata/wr latched from the granted requester at that edge.
REQ-018 Instruction grant SHALL drive o_m_wr=0, o_m_ben=4'hF, o_m_wdata=0.
REQ-019 Memory command outputs SHALL hold stable through D_XFER/I_XFER regardless of requester input changes (requester deasserting mid-transfer is ignored).
REQ-020 i_m_ack high in XFER SHALL: drop o_m_req next edge, latch i_m_rdata into granted o_x_rdata (reads only; writes leave o_d_rdata unchanged), enter ACK.
REQ-021 In ACK, granted o_x_ack SHALL be high exactly one cycle; requests SHALL be ignored; next state IDLE.
REQ-022 Wait counter SHALL clear on grant, increment each XFER cycle without i_m_ack; reaching TIMEOUT SHALL drop o_m_req, enter ACK, assert o_x_abort with o_x_ack, rdata unchanged.
REQ-023 o_x_abort SHALL be high only together with o_x_ack.
REQ-024 i_m_ack outside XFER SHALL be ignored.
REQ-025 i_m_ack on the same cycle the wait counter reaches TIMEOUT SHALL complete normally (no abort).
REQ-026 Minimum request-to-ack latency SHALL be 3 cycles (IDLE sample, XFER with immediate i_m_ack, ACK).
REQ-027 Requester SHALL deassert or change its request by the end of its ACK cycle; a request still high in IDLE is a new transfer.

Reset
REQ-028 i_reset_n low at an edge SHALL force IDLE, clear both counters, drive o_m_req, o_m_wr, o_d_ack, o_i_ack, o_d_abort, o_i_abort, o_busy to 0, o_m_addr, o_m_ben, o_m_wdata, o_d_rdata, o_i_rdata to 0.
REQ-029 Reset mid-transfer SHALL abandon the transfer with no ack/abort pulse; subsequent i_m_ack ignored.

Verification
REQ-030 Single read: i_d_req, addr 0x100, i_m_ack one cycle after o_m_req with rdata 0xDEADBEEF -> o_d_ack one cycle, o_d_rdata=0xDEADBEEF, 3-cycle latency.
REQ-031 Contention: i_d_req and i_i_req held continuously, memory acks immediately -> grants D,D,D,D,I repeating with MAX_D_BURST=4.
REQ-032 Timeout: i_i_req, i_m_ack never asserted -> o_i_ack and o_i_abort high together 15 XFER cycles after grant, o_m_req low.
REQ-033 Write: i_d_wr=1, ben 4'b0011, wdata 0x1234ABCD -> o_m_wr=1, o_m_ben=0011, wdata held until i_m_ack; o_d_rdata unchanged.
REQ-034 Reset mid-XFER: i_reset_n low for one edge during D_XFER -> all outputs zero next cycle, no o_d_ack; late i_m_ack ignored.
REQ-035 Ack at limit: i_m_ack arrives on 15th wait cycle -> normal completion, o_i_abort stays 0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for mem_port_arbiter.
// Handshake: a requester holds its req (and qualifiers) high until it sees
// its one-cycle ack; abort is only ever high together with ack. The memory
// sees m_req held high with a stable command until it pulses m_ack (with
// m_rdata valid in that same cycle); m_ack outside a transfer is ignored.
interface mem_port_arbiter_if;
  // data requester
  logic        i_d_req;
  logic        i_d_wr;
  logic [31:0] i_d_addr;
  logic [3:0]  i_d_ben;
  logic [31:0] i_d_wdata;
  logic        o_d_ack;
  logic        o_d_abort;
  logic [31:0] o_d_rdata;
  // instruction requester
  logic        i_i_req;
  logic [31:0] i_i_addr;
  logic        o_i_ack;
  logic        o_i_abort;
  logic [31:0] o_i_rdata;
  // shared memory port
  logic        o_m_req;
  logic        o_m_wr;
  logic [31:0] o_m_addr;
  logic [3:0]  o_m_ben;
  logic [31:0] o_m_wdata;
  logic        i_m_ack;
  logic [31:0] i_m_rdata;

  // arbiter side
  modport slave (
    input  i_d_req, i_d_wr, i_d_addr, i_d_ben, i_d_wdata,
    output o_d_ack, o_d_abort, o_d_rdata,
    input  i_i_req, i_i_addr,
    output o_i_ack, o_i_abort, o_i_rdata,
    output o_m_req, o_m_wr, o_m_addr, o_m_ben, o_m_wdata,
    input  i_m_ack, i_m_rdata
  );

  // requester / memory model side
  modport master (
    output i_d_req, i_d_wr, i_d_addr, i_d_ben, i_d_wdata,
    input  o_d_ack, o_d_abort, o_d_rdata,
    output i_i_req, i_i_addr,
    input  o_i_ack, o_i_abort, o_i_rdata,
    input  o_m_req, o_m_wr, o_m_addr, o_m_ben, o_m_wdata,
    output i_m_ack, i_m_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (data / instruction) arbiter onto a single memory port.
// Data has priority, but after MAX_D_BURST consecutive data grants made while
// an instruction fetch waits, the instruction side gets the next grant.
// Each transfer is IDLE -> XFER -> ACK; a memory that never answers is
// aborted after TIMEOUT wait cycles. All outputs come straight from flops.
module mem_port_arbiter #(
  parameter int MAX_D_BURST = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  mem_port_arbiter_if.slave     bus,
  output logic                  o_busy,
  output logic [1:0]            o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_XFER = 2'd1,
    I_XFER = 2'd2,
    ACK    = 2'd3
  } state_t;

  localparam int          BW        = $clog2(MAX_D_BURST + 1);
  localparam logic [BW-1:0] LP_BMAX = BW'(MAX_D_BURST);
  // Last wait count that may still see an ack; one more idle cycle aborts.
  localparam logic [3:0]  LP_WLAST  = 4'(TIMEOUT - 1);

  state_t        r_state, w_state;
  logic [BW-1:0] r_burst, w_burst;
  logic [3:0]    r_wait,  w_wait;
  logic          r_m_req, w_m_req;
  logic          r_m_wr,  w_m_wr;
  logic [31:0]   r_m_addr, w_m_addr;
  logic [3:0]    r_m_ben,  w_m_ben;
  logic [31:0]   r_m_wdata, w_m_wdata;
  logic          r_d_ack, w_d_ack;
  logic          r_i_ack, w_i_ack;
  logic          r_d_abort, w_d_abort;
  logic          r_i_abort, w_i_abort;
  logic [31:0]   r_d_rdata, w_d_rdata;
  logic [31:0]   r_i_rdata, w_i_rdata;
  logic          r_busy, w_busy;

  // Next-state and next-output computation; every register holds by default,
  // ack/abort default low so they pulse for exactly the ACK cycle.
  always_comb begin
    w_state   = r_state;
    w_burst   = r_burst;
    w_wait    = r_wait;
    w_m_req   = r_m_req;
    w_m_wr    = r_m_wr;
    w_m_addr  = r_m_addr;
    w_m_ben   = r_m_ben;
    w_m_wdata = r_m_wdata;
    w_d_ack   = 1'b0;
    w_i_ack   = 1'b0;
    w_d_abort = 1'b0;
    w_i_abort = 1'b0;
    w_d_rdata = r_d_rdata;
    w_i_rdata = r_i_rdata;
    case (r_state)
      IDLE: begin
        if (bus.i_d_req && (!bus.i_i_req || r_burst != LP_BMAX)) begin
          w_state   = D_XFER;
          w_m_req   = 1'b1;
          w_m_wr    = bus.i_d_wr;
          w_m_addr  = bus.i_d_addr;
          w_m_ben   = bus.i_d_ben;
          w_m_wdata = bus.i_d_wdata;
          w_wait    = 4'd0;
          // only grants that make a waiting fetch wait longer are counted
          w_burst   = bus.i_i_req ? r_burst + BW'(1) : '0;
        end else if (bus.i_i_req) begin
          w_state   = I_XFER;
          w_m_req   = 1'b1;
          w_m_wr    = 1'b0;
          w_m_addr  = bus.i_i_addr;
          w_m_ben   = 4'hF;
          w_m_wdata = 32'd0;
          w_wait    = 4'd0;
          w_burst   = '0;
        end else begin
          w_burst   = '0;
        end
      end
      D_XFER, I_XFER: begin
        if (bus.i_m_ack) begin
          w_state = ACK;
          w_m_req = 1'b0;
          if (r_state == D_XFER) begin
            w_d_ack = 1'b1;
            if (!r_m_wr) w_d_rdata = bus.i_m_rdata;
          end else begin
            w_i_ack   = 1'b1;
            w_i_rdata = bus.i_m_rdata;
          end
        end else if (r_wait == LP_WLAST) begin
          w_state = ACK;
          w_m_req = 1'b0;
          if (r_state == D_XFER) begin
            w_d_ack   = 1'b1;
            w_d_abort = 1'b1;
          end else begin
            w_i_ack   = 1'b1;
            w_i_abort = 1'b1;
          end
        end else begin
          w_wait = r_wait + 4'd1;
        end
      end
      ACK: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state   <= IDLE;
      r_burst   <= '0;
      r_wait    <= 4'd0;
      r_m_req   <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= 32'd0;
      r_m_ben   <= 4'd0;
      r_m_wdata <= 32'd0;
      r_d_ack   <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_abort <= 1'b0;
      r_i_abort <= 1'b0;
      r_d_rdata <= 32'd0;
      r_i_rdata <= 32'd0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_burst   <= w_burst;
      r_wait    <= w_wait;
      r_m_req   <= w_m_req;
      r_m_wr    <= w_m_wr;
      r_m_addr  <= w_m_addr;
      r_m_ben   <= w_m_ben;
      r_m_wdata <= w_m_wdata;
      r_d_ack   <= w_d_ack;
      r_i_ack   <= w_i_ack;
      r_d_abort <= w_d_abort;
      r_i_abort <= w_i_abort;
      r_d_rdata <= w_d_rdata;
      r_i_rdata <= w_i_rdata;
      r_busy    <= w_busy;
    end
  end

  assign bus.o_m_req   = r_m_req;
  assign bus.o_m_wr    = r_m_wr;
  assign bus.o_m_addr  = r_m_addr;
  assign bus.o_m_ben   = r_m_ben;
  assign bus.o_m_wdata = r_m_wdata;
  assign bus.o_d_ack   = r_d_ack;
  assign bus.o_i_ack   = r_i_ack;
  assign bus.o_d_abort = r_d_abort;
  assign bus.o_i_abort = r_i_abort;
  assign bus.o_d_rdata = r_d_rdata;
  assign bus.o_i_rdata = r_i_rdata;
  assign o_busy        = r_busy;
  assign o_dbg_state   = r_state;

endmodule
